i2s_frame_tx: RTL and testbench
===============================

// Module: i2s_frame_tx
// PURPOSE
//  I2S transmitter for the audio output path: serialises one stereo sample pair per frame onto SCLK/LRCK/SDOUT.
//  Bit timing comes entirely from an external one-cycle strobe (ENA_HALF, one per SCLK half-period, 128 per frame).
//  Sits between the note/sample generator (valid/ready sample stream) and the DAC pins; runs at 100 MHz.
//  Holds one pair in a buffer; flags underrun when no sample is ready at frame start.
// PARAMETERS
//  WIDTH  24  sample word width per channel; legal range 1..31; each channel slot is 32 SCLK periods
// PORTS
//  CLK_100M   in   1      system clock, all logic on rising edge
//  RST_N      in   1      synchronous reset, active low
//  ENA_HALF   in   1      one-cycle strobe, one per SCLK half-period; strobes at least 2 clocks apart
//  IN_L       in   WIDTH  left sample, two's complement
//  IN_R       in   WIDTH  right sample, two's complement
//  IN_VALID   in   1      IN_L/IN_R hold a valid pair
//  IN_READY   out  1      buffer empty; a pair is accepted on IN_VALID & IN_READY
//  SCLK       out  1      I2S bit clock, 64 periods per frame
//  LRCK       out  1      word select: 0 = left, 1 = right
//  SDOUT      out  1      serial data, MSB first, changes only on SCLK falling edges
//  FRAME_START out 1      one-cycle pulse when a new frame (left slot 0) begins
//  UNDERRUN   out  1      sticky; set when a frame starts with the buffer empty
// BEHAVIOUR
//  Reset (RST_N=0 at a clock edge): hcnt=127, SCLK=0, LRCK=1, SDOUT=0, FRAME_START=0, UNDERRUN=0.
//  Reset also clears the buffer (IN_READY=1) and clears both shift words to 0.
//  Reset mid-frame abandons the frame; nothing resumes.
//  hcnt[6:0]: on each ENA_HALF, hcnt <= hcnt+1, wrapping 127->0. No strobe means no state change, except the input handshake.
//  All outputs are registered and update on the clock edge where ENA_HALF is sampled high (1-cycle latency).
//  SCLK <= hcnt_next[0]: even hcnt gives low, odd gives high. A falling edge therefore starts every bit slot.
//  Slot b = hcnt_next[6:1] (0..63); channel = b[5]; s = b[4:0].
//  On strobes with hcnt_next even:
//   - LRCK <= b[5].
//   - SDOUT <= word_ch[WIDTH-s] when 1 <= s <= WIDTH, else 0, where word_ch = b[5] ? RW : LW.
//   - This gives the standard I2S one-bit delay: the MSB appears in slot 1 of each channel.
//  Frame start, on the strobe where hcnt wraps 127->0:
//   - If the buffer is full: LW <= buf_L, RW <= buf_R, buffer empties.
//   - If the buffer is empty: LW = RW = 0 for this frame, UNDERRUN <= 1.
//   - FRAME_START pulses high for exactly that one cycle.
//  Input handshake: IN_READY = ~buf_full, combinational from the buffer flag.
//   - An accept on IN_VALID & IN_READY loads buf_L/buf_R and sets buf_full on the same edge.
//   - The handshake is independent of ENA_HALF.
//  Simultaneous accept and frame start with the buffer empty:
//   - The accepted pair enters the buffer and is used at the NEXT frame.
//   - The current frame sends zeros and sets UNDERRUN.
//  Frame start with the buffer full: the buffer drains at that edge. IN_READY rises the next cycle, not the same cycle.
//  Frame start is the first strobe after reset, then every 128 strobes. Slot-0 data is always 0 because WIDTH <= 31.
//  UNDERRUN clears only on reset.
// TESTING
//  1. Reset with ENA_HALF idle -> SCLK=0, LRCK=1, SDOUT=0, IN_READY=1, UNDERRUN=0; all held indefinitely.
//  2. Push L=24'hA5A5A5, R=24'h3C0F01, then strobe every 4 clks:
//     - FRAME_START on the 1st strobe; LRCK=0 for 64 strobes, then 1.
//     - SDOUT at SCLK rising edges of slots 1..24 = A5A5A5 MSB first; slots 25..31 = 0.
//     - Slots 33..56 = 3C0F01 MSB first.
//  3. Never assert IN_VALID -> every frame's SDOUT is all 0; UNDERRUN=1 from the 1st frame start and stays 1.
//  4. Assert IN_VALID in the exact cycle of a frame-start strobe with the buffer empty ->
//     - Pair accepted, current frame all 0, UNDERRUN=1.
//     - That pair is transmitted in the following frame.
//  5. Hold IN_VALID high with an incrementing pattern -> exactly one accept per frame, about 1 cycle after FRAME_START.
//     - No pair is dropped or repeated; IN_READY stays low otherwise.
//  6. Assert RST_N=0 at slot 40 mid-frame ->
//     - Outputs return to reset values; the buffer empties.
//     - The next strobe after release starts a fresh frame (FRAME_START=1, LRCK=0).
//  7. Run with WIDTH=16: MSB appears in slot 1; slots 17..31 and 49..63 are 0.

Source files
------------

// File: rtl/i2s_frame_tx.sv
// I2S transmitter: one stereo pair per 128-strobe frame on SCLK/LRCK/SDOUT.
// Single-pair input buffer; sticky underrun when a frame starts empty.
module i2s_frame_tx #(
  parameter int WIDTH = 24
) (
  input  logic             CLK_100M,
  input  logic             RST_N,
  input  logic             ENA_HALF,
  input  logic [WIDTH-1:0] IN_L,
  input  logic [WIDTH-1:0] IN_R,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SCLK,
  output logic             LRCK,
  output logic             SDOUT,
  output logic             FRAME_START,
  output logic             UNDERRUN
);

  logic [6:0]       hcnt;
  logic [6:0]       hcnt_nx;
  logic [5:0]       slot;
  logic [4:0]       sbit;
  logic [4:0]       sidx;
  logic [31:0]      word_al;
  logic             bit_nx;
  logic             fs;
  logic             accept;
  logic [WIDTH-1:0] lw;
  logic [WIDTH-1:0] rw;
  logic [WIDTH-1:0] buf_l;
  logic [WIDTH-1:0] buf_r;
  logic             buf_full;

  // Next half-period position and the data bit for the upcoming slot.
  // The word is left-aligned in 32 bits so slot s reads bit 32-s;
  // slots past WIDTH fall into the zero padding.
  always_comb begin
    hcnt_nx = hcnt + 7'd1;
    slot    = hcnt_nx[6:1];
    sbit    = slot[4:0];
    sidx    = 5'd0 - sbit;
    word_al = {(slot[5] ? rw : lw), {(32-WIDTH){1'b0}}};
    bit_nx  = (sbit != 5'd0) && word_al[sidx];
    fs      = ENA_HALF && (hcnt == 7'd127);
    accept  = IN_VALID && !buf_full;
  end

  assign IN_READY = ~buf_full;

  // Bit-clock counter and registered serial outputs.
  always_ff @(posedge CLK_100M) begin
    if (!RST_N) begin
      hcnt        <= 7'd127;
      SCLK        <= 1'b0;
      LRCK        <= 1'b1;
      SDOUT       <= 1'b0;
      FRAME_START <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      FRAME_START <= fs;
      if (ENA_HALF) begin
        hcnt <= hcnt_nx;
        SCLK <= hcnt_nx[0];
        if (!hcnt_nx[0]) begin
          LRCK  <= slot[5];
          SDOUT <= bit_nx;
        end
      end
      if (fs && !buf_full) begin
        UNDERRUN <= 1'b1;
      end
    end
  end

  // Input buffer and per-frame words; a frame start drains the buffer.
  always_ff @(posedge CLK_100M) begin
    if (!RST_N) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
      lw       <= '0;
      rw       <= '0;
    end else begin
      if (accept) begin
        buf_l    <= IN_L;
        buf_r    <= IN_R;
        buf_full <= 1'b1;
      end
      if (fs) begin
        if (buf_full) begin
          lw       <= buf_l;
          rw       <= buf_r;
          buf_full <= 1'b0;
        end else begin
          lw <= '0;
          rw <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Bench for i2s_frame_tx: directed steps, expected frames queued at
// frame start from a behavioural buffer model, compared at frame end.
module tb_i2s_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic [23:0] in_l;
  logic [23:0] in_r;

  logic ready, sclk, lrck, sdout, fst, und;
  logic ready16, sclk16, lrck16, sdout16, fst16, und16;

  always #5 clk = ~clk;

  i2s_frame_tx #(.WIDTH(24)) dut (
    .CLK_100M(clk), .RST_N(rst_n), .ENA_HALF(ena),
    .IN_L(in_l), .IN_R(in_r), .IN_VALID(in_valid),
    .IN_READY(ready), .SCLK(sclk), .LRCK(lrck), .SDOUT(sdout),
    .FRAME_START(fst), .UNDERRUN(und)
  );

  i2s_frame_tx #(.WIDTH(16)) dut16 (
    .CLK_100M(clk), .RST_N(rst_n), .ENA_HALF(ena),
    .IN_L(in_l[15:0]), .IN_R(in_r[15:0]), .IN_VALID(in_valid),
    .IN_READY(ready16), .SCLK(sclk16), .LRCK(lrck16), .SDOUT(sdout16),
    .FRAME_START(fst16), .UNDERRUN(und16)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] q24[$];
  logic [63:0] q16[$];

  logic        m_full, m_under, m_acc;
  logic [23:0] m_l, m_r;
  logic [6:0]  m_h;

  logic [6:0]  t_h;
  logic        in_frame;
  logic [63:0] got24, got16;
  logic        auto_feed = 1'b0;
  logic        fs_valid = 1'b0;

  // Expected 64 slot bits of a frame, slot 0 at bit 63.
  function automatic logic [63:0] fbits(input logic [23:0] l,
                                        input logic [23:0] r,
                                        input int w);
    logic [63:0] f;
    logic [23:0] wd;
    int s;
    f = '0;
    for (int b = 0; b < 64; b++) begin
      s  = b % 32;
      wd = (b >= 32) ? r : l;
      if (s >= 1 && s <= w) f[63-b] = wd[w-s];
    end
    return f;
  endfunction

  // Behavioural buffer model; queues each frame's expected bits.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_full  <= 1'b0;
      m_under <= 1'b0;
      m_acc   <= 1'b0;
      m_h     <= 7'd127;
      q24.delete();
      q16.delete();
    end else begin
      m_acc <= in_valid && !m_full;
      if (ena && m_h == 7'd127) begin
        if (m_full) begin
          q24.push_back(fbits(m_l, m_r, 24));
          q16.push_back(fbits(m_l, m_r, 16));
        end else begin
          q24.push_back(64'd0);
          q16.push_back(64'd0);
          m_under <= 1'b1;
        end
      end
      if (in_valid && !m_full) begin
        m_l    <= in_l;
        m_r    <= in_r;
        m_full <= 1'b1;
      end else if (ena && m_h == 7'd127) begin
        m_full <= 1'b0;
      end
      if (ena) m_h <= m_h + 7'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (auto_feed && m_acc) begin
      in_l = in_l + 24'h1;
      in_r = in_r - 24'h3;
    end
  endtask

  task automatic strobe();
    repeat (3) tick();
    ena = 1'b1;
    if (fs_valid && t_h == 7'd127) in_valid = 1'b1;
    tick();
    ena = 1'b0;
    if (fs_valid) in_valid = 1'b0;
    t_h = t_h + 7'd1;
    if (t_h == 7'd0) in_frame = 1'b1;
    chk("sclk", sclk, t_h[0]);
    chk("frame_start", fst, t_h == 7'd0);
    if (!t_h[0]) chk("lrck", lrck, t_h[6]);
    chk("underrun", und, m_under);
    chk("in_ready", ready, !m_full);
    if (t_h[0]) begin
      got24[63-t_h[6:1]] = sdout;
      got16[63-t_h[6:1]] = sdout16;
    end
    if (t_h == 7'd127 && in_frame) begin
      checks++;
      assert (q24.size() > 0 && q16.size() > 0) else begin
        errors++;
        $error("FAIL scoreboard got empty exp frame");
      end
      if (q24.size() > 0 && q16.size() > 0) begin
        chk("frame24", got24, q24.pop_front());
        chk("frame16", got16, q16.pop_front());
      end
      in_frame = 1'b0;
    end
  endtask

  task automatic frames(input int n);
    repeat (n * 128) strobe();
  endtask

  task automatic chk_reset_vals();
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_lrck", lrck, 1'b1);
    chk("rst_sdout", sdout, 1'b0);
    chk("rst_fs", fst, 1'b0);
    chk("rst_underrun", und, 1'b0);
    chk("rst_ready", ready, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    chk_reset_vals();
    rst_n    = 1'b1;
    t_h      = 7'd127;
    in_frame = 1'b0;
    got24    = '0;
    got16    = '0;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    chk("push_ready", ready, 1'b1);
    in_l     = l;
    in_r     = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("push_taken", ready, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b0;
    in_valid = 1'b0;
    in_l     = '0;
    in_r     = '0;
    tick();
    do_reset();
    repeat (20) tick();
    chk_reset_vals();

    push(24'hA5A5A5, 24'h3C0F01);
    frames(1);
    frames(1);

    in_l     = 24'h123456;
    in_r     = 24'hFEDCBA;
    fs_valid = 1'b1;
    strobe();
    fs_valid = 1'b0;
    chk("fs_accept", ready, 1'b0);
    repeat (127) strobe();
    frames(1);

    in_l      = 24'h100000;
    in_r      = 24'h7FFFF0;
    auto_feed = 1'b1;
    in_valid  = 1'b1;
    frames(4);
    in_valid  = 1'b0;
    auto_feed = 1'b0;

    repeat (81) strobe();
    do_reset();
    strobe();
    repeat (127) strobe();
    push(24'h80F1C3, 24'h5A0001);
    frames(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
